mem_wr_reg: RTL and testbench

- Pipeline register between the Mem stage and the Wr (write-back) stage of the 5-stage CPU.
- Captures the Mem-stage results and control, and aligns and extends load data before registering it.
- Resolves the destination register number.
- Drives the write-back mux inputs (ALU_ans_Wr, Mem_Data_Wr, PC_Addr_Wr, MemToReg_Wr, Rtype_L_Wr, Jal_Wr) and the register-file write port and forwarding sources (Rw_Wr, RegWr_Wr).

---
 rtl/mem_wr_reg_pkg.sv | 33 +++
 rtl/mem_wr_reg_load_align.sv | 29 ++
 rtl/mem_wr_reg.sv | 96 +++++++++
 tb/tb_mem_wr_reg.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wr_reg_pkg.sv
// Shared definitions for the Mem/Wr pipeline register and the decoder.
package mem_wr_reg_pkg;

    // Load width/sign codes carried down the pipe from the decoder.
    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    // Link register written by jal.
    localparam logic [4:0] REG_RA = 5'd31;

    // Destination register: jal forces $31, otherwise rd or rt by RegDst.
    function automatic logic [4:0] resolve_rw(
        input logic       jal,
        input logic       reg_dst,
        input logic [4:0] rd,
        input logic [4:0] rt
    );
        logic [4:0] rw;
        if (jal)
            rw = REG_RA;
        else if (reg_dst)
            rw = rd;
        else
            rw = rt;
        return rw;
    endfunction

endpackage

// File: rtl/mem_wr_reg_load_align.sv
// Little-endian load alignment and sign/zero extension of a memory word.
module load_align
    import mem_wr_reg_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{off, 3'b000} +: 8];
    assign half_sel = word[{off[1], 4'b0000} +: 16];

    // Pick the addressed byte/halfword and extend it; unknown codes load the whole word.
    always_comb begin
        result = word;
        case (load_type_e'(load_type))
            LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result = {24'd0, byte_sel};
            LT_LH:   result = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_wr_reg.sv
// Mem -> Wr pipeline register with load alignment, destination resolution
// and a retired-instruction counter.
module mem_wr_reg
    import mem_wr_reg_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ALU_ans_Mem,
    input  logic [31:0]      Mem_Data_Mem,
    input  logic [31:0]      PC_Addr_Mem,
    input  logic             MemToReg_Mem,
    input  logic             Rtype_L_Mem,
    input  logic             Jal_Mem,
    input  logic             RegWr_Mem,
    input  logic             RegDst_Mem,
    input  logic [4:0]       Rd_Mem,
    input  logic [4:0]       Rt_Mem,
    input  logic [2:0]       LoadType_Mem,
    input  logic             Valid_Mem,
    input  logic             Stall_Wr,
    input  logic             Flush_Wr,
    output logic [31:0]      ALU_ans_Wr,
    output logic [31:0]      Mem_Data_Wr,
    output logic [31:0]      PC_Addr_Wr,
    output logic             MemToReg_Wr,
    output logic             Rtype_L_Wr,
    output logic             Jal_Wr,
    output logic             RegWr_Wr,
    output logic [4:0]       Rw_Wr,
    output logic             Valid_Wr,
    output logic [CNT_W-1:0] Retired_Cnt
);

    logic [31:0] aligned_data;
    logic [4:0]  rw_next;
    logic        regwr_next;
    logic        load_en;

    load_align u_load_align (
        .word      (Mem_Data_Mem),
        .off       (ALU_ans_Mem[1:0]),
        .load_type (LoadType_Mem),
        .result    (aligned_data)
    );

    assign rw_next    = resolve_rw(Jal_Mem, RegDst_Mem, Rd_Mem, Rt_Mem);
    assign regwr_next = RegWr_Mem & Valid_Mem & (rw_next != 5'd0);
    assign load_en    = !Flush_Wr && !Stall_Wr;

    // Pipeline register: flush inserts a bubble, stall holds, otherwise capture Mem.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_ans_Wr  <= '0;
            Mem_Data_Wr <= '0;
            PC_Addr_Wr  <= '0;
            MemToReg_Wr <= 1'b0;
            Rtype_L_Wr  <= 1'b0;
            Jal_Wr      <= 1'b0;
            RegWr_Wr    <= 1'b0;
            Rw_Wr       <= '0;
            Valid_Wr    <= 1'b0;
        end else if (Flush_Wr) begin
            ALU_ans_Wr  <= '0;
            Mem_Data_Wr <= '0;
            PC_Addr_Wr  <= '0;
            MemToReg_Wr <= 1'b0;
            Rtype_L_Wr  <= 1'b0;
            Jal_Wr      <= 1'b0;
            RegWr_Wr    <= 1'b0;
            Rw_Wr       <= '0;
            Valid_Wr    <= 1'b0;
        end else if (!Stall_Wr) begin
            ALU_ans_Wr  <= ALU_ans_Mem;
            Mem_Data_Wr <= aligned_data;
            PC_Addr_Wr  <= PC_Addr_Mem + LINK_OFFSET;
            MemToReg_Wr <= MemToReg_Mem;
            Rtype_L_Wr  <= Rtype_L_Mem;
            Jal_Wr      <= Jal_Mem;
            RegWr_Wr    <= regwr_next;
            Rw_Wr       <= rw_next;
            Valid_Wr    <= Valid_Mem;
        end
    end

    // Count valid instructions entering Wr; bubbles and held cycles do not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Retired_Cnt <= '0;
        else if (load_en && Valid_Mem)
            Retired_Cnt <= Retired_Cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mem_wr_reg.sv
// Self-checking bench for mem_wr_reg: vector table, directed corner cases
// and randomized traffic against a behavioural model.
module tb_mem_wr_reg;

    logic        clk;
    logic        rst_n;
    logic [31:0] ALU_ans_Mem;
    logic [31:0] Mem_Data_Mem;
    logic [31:0] PC_Addr_Mem;
    logic        MemToReg_Mem;
    logic        Rtype_L_Mem;
    logic        Jal_Mem;
    logic        RegWr_Mem;
    logic        RegDst_Mem;
    logic [4:0]  Rd_Mem;
    logic [4:0]  Rt_Mem;
    logic [2:0]  LoadType_Mem;
    logic        Valid_Mem;
    logic        Stall_Wr;
    logic        Flush_Wr;

    logic [31:0] ALU_ans_Wr, Mem_Data_Wr, PC_Addr_Wr;
    logic        MemToReg_Wr, Rtype_L_Wr, Jal_Wr, RegWr_Wr, Valid_Wr;
    logic [4:0]  Rw_Wr;
    logic [31:0] Retired_Cnt;

    logic [31:0] ALU_ans_Wr4, Mem_Data_Wr4, PC_Addr_Wr4;
    logic        MemToReg_Wr4, Rtype_L_Wr4, Jal_Wr4, RegWr_Wr4, Valid_Wr4;
    logic [4:0]  Rw_Wr4;
    logic [3:0]  Retired_Cnt4;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [31:0] pc;
        logic        m2r;
        logic        rtl;
        logic        jal;
        logic        regwr;
        logic [4:0]  rw;
        logic        valid;
    } wr_t;

    wr_t         exp_s;
    logic [31:0] exp_cnt;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  off;
        logic [2:0]  lt;
        logic [31:0] expect_data;
    } align_vec_t;

    mem_wr_reg #(.LINK_OFFSET(32'd4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALU_ans_Mem(ALU_ans_Mem), .Mem_Data_Mem(Mem_Data_Mem), .PC_Addr_Mem(PC_Addr_Mem),
        .MemToReg_Mem(MemToReg_Mem), .Rtype_L_Mem(Rtype_L_Mem), .Jal_Mem(Jal_Mem),
        .RegWr_Mem(RegWr_Mem), .RegDst_Mem(RegDst_Mem), .Rd_Mem(Rd_Mem), .Rt_Mem(Rt_Mem),
        .LoadType_Mem(LoadType_Mem), .Valid_Mem(Valid_Mem), .Stall_Wr(Stall_Wr), .Flush_Wr(Flush_Wr),
        .ALU_ans_Wr(ALU_ans_Wr), .Mem_Data_Wr(Mem_Data_Wr), .PC_Addr_Wr(PC_Addr_Wr),
        .MemToReg_Wr(MemToReg_Wr), .Rtype_L_Wr(Rtype_L_Wr), .Jal_Wr(Jal_Wr),
        .RegWr_Wr(RegWr_Wr), .Rw_Wr(Rw_Wr), .Valid_Wr(Valid_Wr), .Retired_Cnt(Retired_Cnt)
    );

    mem_wr_reg #(.LINK_OFFSET(32'd4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .ALU_ans_Mem(ALU_ans_Mem), .Mem_Data_Mem(Mem_Data_Mem), .PC_Addr_Mem(PC_Addr_Mem),
        .MemToReg_Mem(MemToReg_Mem), .Rtype_L_Mem(Rtype_L_Mem), .Jal_Mem(Jal_Mem),
        .RegWr_Mem(RegWr_Mem), .RegDst_Mem(RegDst_Mem), .Rd_Mem(Rd_Mem), .Rt_Mem(Rt_Mem),
        .LoadType_Mem(LoadType_Mem), .Valid_Mem(Valid_Mem), .Stall_Wr(Stall_Wr), .Flush_Wr(Flush_Wr),
        .ALU_ans_Wr(ALU_ans_Wr4), .Mem_Data_Wr(Mem_Data_Wr4), .PC_Addr_Wr(PC_Addr_Wr4),
        .MemToReg_Wr(MemToReg_Wr4), .Rtype_L_Wr(Rtype_L_Wr4), .Jal_Wr(Jal_Wr4),
        .RegWr_Wr(RegWr_Wr4), .Rw_Wr(Rw_Wr4), .Valid_Wr(Valid_Wr4), .Retired_Cnt(Retired_Cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference load alignment written from the byte/halfword rules with plain arithmetic.
    function automatic logic [31:0] align_ref(input logic [31:0] data, input logic [1:0] off,
                                              input logic [2:0] lt);
        logic [31:0] b, h;
        b = (data >> (8 * off)) & 32'h0000_00FF;
        h = (data >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (lt)
            3'd1:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return data;
        endcase
    endfunction

    task automatic model_reset();
        exp_s   = '{default: '0};
        exp_cnt = '0;
    endtask

    // Behavioural next state of the Wr slot, evaluated at each rising edge.
    task automatic model_step();
        logic [4:0] rw;
        if (!rst_n) begin
            model_reset();
        end else if (Flush_Wr) begin
            exp_s = '{default: '0};
        end else if (!Stall_Wr) begin
            rw = Jal_Mem ? 5'd31 : (RegDst_Mem ? Rd_Mem : Rt_Mem);
            exp_s.alu   = ALU_ans_Mem;
            exp_s.mdata = align_ref(Mem_Data_Mem, ALU_ans_Mem[1:0], LoadType_Mem);
            exp_s.pc    = PC_Addr_Mem + 32'd4;
            exp_s.m2r   = MemToReg_Mem;
            exp_s.rtl   = Rtype_L_Mem;
            exp_s.jal   = Jal_Mem;
            exp_s.rw    = rw;
            exp_s.regwr = RegWr_Mem && Valid_Mem && (rw != 5'd0);
            exp_s.valid = Valid_Mem;
            if (Valid_Mem) exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        check32({tag, ".ALU_ans_Wr"},  ALU_ans_Wr,  exp_s.alu);
        check32({tag, ".Mem_Data_Wr"}, Mem_Data_Wr, exp_s.mdata);
        check32({tag, ".PC_Addr_Wr"},  PC_Addr_Wr,  exp_s.pc);
        check32({tag, ".ctrl"}, {29'd0, MemToReg_Wr, Rtype_L_Wr, Jal_Wr},
                {29'd0, exp_s.m2r, exp_s.rtl, exp_s.jal});
        check32({tag, ".RegWr_Wr"}, {31'd0, RegWr_Wr}, {31'd0, exp_s.regwr});
        check32({tag, ".Rw_Wr"},    {27'd0, Rw_Wr},    {27'd0, exp_s.rw});
        check32({tag, ".Valid_Wr"}, {31'd0, Valid_Wr}, {31'd0, exp_s.valid});
        check32({tag, ".Retired_Cnt"},  Retired_Cnt, exp_cnt);
        check32({tag, ".Retired_Cnt4"}, {28'd0, Retired_Cnt4}, {28'd0, exp_cnt[3:0]});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        checkOutput(tag);
    endtask

    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] data, input logic [31:0] pc,
                                 input logic [2:0] lt, input logic jal, input logic reg_dst,
                                 input logic [4:0] rd, input logic [4:0] rt, input logic regwr,
                                 input logic valid, input logic stall, input logic flush);
        ALU_ans_Mem  = alu;
        Mem_Data_Mem = data;
        PC_Addr_Mem  = pc;
        LoadType_Mem = lt;
        Jal_Mem      = jal;
        RegDst_Mem   = reg_dst;
        Rd_Mem       = rd;
        Rt_Mem       = rt;
        RegWr_Mem    = regwr;
        Valid_Mem    = valid;
        Stall_Wr     = stall;
        Flush_Wr     = flush;
        MemToReg_Mem = 1'b1;
        Rtype_L_Mem  = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checkOutput("async_reset");
        @(negedge clk);
        @(posedge clk);
        model_step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    align_vec_t vecs[$];

    initial begin
        // Vectors: the test-plan word at offset 2 plus other offsets and codes.
        vecs.push_back('{32'h80FF7F01, 2'b10, 3'd1, 32'hFFFFFFFF});
        vecs.push_back('{32'h80FF7F01, 2'b10, 3'd2, 32'h000000FF});
        vecs.push_back('{32'h80FF7F01, 2'b10, 3'd3, 32'hFFFF80FF});
        vecs.push_back('{32'h80FF7F01, 2'b10, 3'd4, 32'h000080FF});
        vecs.push_back('{32'h80FF7F01, 2'b10, 3'd0, 32'h80FF7F01});
        vecs.push_back('{32'h80FF7F01, 2'b00, 3'd1, 32'h00000001});
        vecs.push_back('{32'h80FF7F01, 2'b01, 3'd1, 32'h0000007F});
        vecs.push_back('{32'h80FF7F01, 2'b11, 3'd1, 32'hFFFFFF80});
        vecs.push_back('{32'h80FF7F01, 2'b01, 3'd4, 32'h00007F01});
        vecs.push_back('{32'h80FF7F01, 2'b11, 3'd3, 32'hFFFF80FF});
        vecs.push_back('{32'h80FF7F01, 2'b11, 3'd5, 32'h80FF7F01});
        vecs.push_back('{32'h80FF7F01, 2'b01, 3'd7, 32'h80FF7F01});

        // Reset with nonzero inputs: outputs zero before any clock edge.
        rst_n = 1'b0;
        applyStimulus(32'hDEAD_BEEE, 32'h1234_5678, 32'h0000_1000, 3'd2, 1'b0, 1'b1,
                      5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        model_reset();
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("first_load");
        check32("first_load.Rw", {27'd0, Rw_Wr}, 32'd9);

        // Alignment table.
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus({30'h0, vecs[i].off}, vecs[i].data, 32'h100, vecs[i].lt,
                          1'b0, 1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            tick($sformatf("align%0d", i));
            check32($sformatf("align%0d.table", i), Mem_Data_Wr, vecs[i].expect_data);
        end

        // Jal beats RegDst and writes the link address.
        @(negedge clk);
        applyStimulus(32'h0, 32'h0, 32'h0000_3000, 3'd0, 1'b1, 1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        tick("jal");
        check32("jal.Rw", {27'd0, Rw_Wr}, 32'd31);
        check32("jal.PC", PC_Addr_Wr, 32'h0000_3004);
        check32("jal.RegWr", {31'd0, RegWr_Wr}, 32'd1);

        // Writes to $0 are suppressed.
        @(negedge clk);
        applyStimulus(32'h55, 32'h66, 32'h0, 3'd0, 1'b0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick("zero_reg");
        check32("zero_reg.RegWr", {31'd0, RegWr_Wr}, 32'd0);
        check32("zero_reg.Valid", {31'd0, Valid_Wr}, 32'd1);

        // Invalid slot still loads data but cannot write.
        @(negedge clk);
        applyStimulus(32'h77, 32'h88, 32'h20, 3'd0, 1'b0, 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("invalid");

        // Stall / flush / counter sequence from a fresh reset.
        async_reset();
        applyStimulus(32'hA0A0_A0A0, 32'h1111_2222, 32'h400, 3'd0, 1'b0, 1'b1, 5'd12, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick("load_A");
        check32("load_A.cnt", Retired_Cnt, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            applyStimulus($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'b1, 1'b0,
                          5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
            tick($sformatf("stall%0d", k));
            check32($sformatf("stall%0d.alu", k), ALU_ans_Wr, 32'hA0A0_A0A0);
            check32($sformatf("stall%0d.cnt", k), Retired_Cnt, 32'd1);
        end
        @(negedge clk);
        Flush_Wr = 1'b1;
        tick("stall_flush");
        check32("stall_flush.alu", ALU_ans_Wr, 32'h0);
        check32("stall_flush.cnt", Retired_Cnt, 32'd1);

        // Counter wrap on the 4-bit instance, with invalid loads interleaved.
        async_reset();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(32'(k), 32'h0, 32'(k), 3'd0, 1'b0, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
            tick($sformatf("wrap%0d", k));
            @(negedge clk);
            if (k % 4 == 1) begin
                Valid_Mem = 1'b0;
                tick($sformatf("wrap_inv%0d", k));
                @(negedge clk);
            end
        end
        check32("wrap.cnt4", {28'd0, Retired_Cnt4}, 32'd0);
        check32("wrap.cnt32", Retired_Cnt, 32'd16);

        // Randomized traffic, including a mid-stream reset.
        for (int k = 0; k < 300; k++) begin
            applyStimulus($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom), 5'($urandom),
                          1'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0));
            MemToReg_Mem = 1'($urandom);
            Rtype_L_Mem  = 1'($urandom);
            tick($sformatf("rand%0d", k));
            if (k == 150)
                async_reset();
            else
                @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
